exec_unit_v2: RTL and testbench

Parametrised successor of the core's execute stage. It takes one decoded integer instruction per handshake, forwards operands from its own last writeback, and resolves branches and jumps. It runs loads and stores against a memory with configurable read latency, and runs an iterative unsigned divide/remainder in place of the fixed divide-by-10. It sits between decode/register-read and register writeback. It replaces the enable/done pulse pair with in_valid/in_ready.

---
 rtl/exec_unit_v2_pkg.sv | 17 +
 rtl/exec_unit_v2_divider.sv | 51 +++++
 rtl/exec_unit_v2.sv | 209 ++++++++++++++++++++
 tb/tb_exec_unit_v2.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/exec_unit_v2_pkg.sv
// Shared encodings for the execute stage: opcode and FSM state enums, immediate helper.
package exec_pkg;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
    OP_SLL, OP_SRL, OP_SRA, OP_ADDI, OP_ANDI, OP_ORI, OP_XORI,
    OP_BEQ, OP_BNE, OP_J_R, OP_JAL_R, OP_LW, OP_SW, OP_DIVU, OP_REMU
  } op_t;

  typedef enum logic [1:0] {IDLE, MEM, DIV} state_t;

  // Callers truncate to their own width with a size cast.
  function automatic logic [63:0] sext16(input logic [15:0] v);
    return {{48{v[15]}}, v};
  endfunction

endpackage

// File: rtl/exec_unit_v2_divider.sv
// Restoring radix-2 unsigned divider, one quotient bit per cycle.
// done/quotient/remainder are valid combinationally in the final iteration cycle.
module exec_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            done_o,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);
  localparam int CW = $clog2(XLEN);

  logic            busy_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] a_q, r_q, d_q;
  logic [XLEN:0]   sh, diff;
  logic            qbit;

  // a_q shifts the dividend out at the top while quotient bits enter at the bottom.
  assign sh          = {r_q, a_q[XLEN-1]};
  assign diff        = sh - {1'b0, d_q};
  assign qbit        = ~diff[XLEN];
  assign quotient_o  = {a_q[XLEN-2:0], qbit};
  assign remainder_o = qbit ? diff[XLEN-1:0] : sh[XLEN-1:0];
  assign done_o      = busy_q && (cnt_q == CW'(XLEN-1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      a_q    <= '0;
      r_q    <= '0;
      d_q    <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      a_q    <= dividend_i;
      r_q    <= '0;
      d_q    <= divisor_i;
    end else if (busy_q) begin
      a_q   <= quotient_o;
      r_q   <= remainder_o;
      cnt_q <= cnt_q + 1'b1;
      if (done_o) busy_q <= 1'b0;
    end
  end
endmodule

// File: rtl/exec_unit_v2.sv
// Execute stage: ALU, branches/jumps, load/store with fixed memory latency, iterative divide.
// Operands are forwarded from the unit's own most recent register writeback.
module exec_unit_v2
  import exec_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 19,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        op,
  input  logic [4:0]        rs_no,
  input  logic [4:0]        rt_no,
  input  logic [4:0]        rd_no,
  input  logic [XLEN-1:0]   rs_val,
  input  logic [XLEN-1:0]   rt_val,
  input  logic [15:0]       imm,
  input  logic [XLEN-1:0]   pc,
  output logic              out_valid,
  output logic              out_we,
  output logic [4:0]        out_rd,
  output logic [XLEN-1:0]   out_data,
  output logic              redirect,
  output logic [XLEN-1:0]   redirect_pc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              busy
);
  localparam int SHW = $clog2(XLEN);
  localparam int CW  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            out_valid_q, out_valid_d, out_we_q, out_we_d, redirect_q, redirect_d;
  logic [4:0]      out_rd_q, out_rd_d, pend_rd_q, pend_rd_d, lw_rd_q;
  logic [XLEN-1:0] out_data_q, out_data_d, redirect_pc_q, redirect_pc_d, lw_data_q;
  logic            pend_rem_q, pend_rem_d, lw_we_q;

  op_t             op_e;
  logic            accept, alu_ok, div_start, div_done;
  logic [XLEN-1:0] rs_eff, rt_eff, imm_s, imm_z, ea, br_tgt, alu_res, div_q, div_r;

  assign op_e   = op_t'(op);
  assign accept = in_valid && in_ready;
  assign rs_eff = (lw_we_q && lw_rd_q == rs_no && rs_no != 5'd0) ? lw_data_q : rs_val;
  assign rt_eff = (lw_we_q && lw_rd_q == rt_no && rt_no != 5'd0) ? lw_data_q : rt_val;
  assign imm_s  = XLEN'(sext16(imm));
  assign imm_z  = XLEN'(imm);
  assign ea     = rs_eff + imm_s;
  assign br_tgt = pc + (imm_s << 2);

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign mem_re    = rstn && accept && (op_e == OP_LW);
  assign mem_we    = rstn && accept && (op_e == OP_SW);
  assign mem_addr  = rstn ? ADDR_W'(ea >> 2) : '0;
  assign mem_wdata = rstn ? rt_eff : '0;
  assign div_start = accept && (op_e == OP_DIVU || op_e == OP_REMU);

  exec_divider #(.XLEN(XLEN)) u_div (
    .clk(clk), .rstn(rstn), .start_i(div_start),
    .dividend_i(rs_eff), .divisor_i(rt_eff),
    .done_o(div_done), .quotient_o(div_q), .remainder_o(div_r)
  );

  always_comb begin
    alu_ok  = 1'b1;
    alu_res = '0;
    case (op_e)
      OP_ADD:  alu_res = rs_eff + rt_eff;
      OP_SUB:  alu_res = rs_eff - rt_eff;
      OP_AND:  alu_res = rs_eff & rt_eff;
      OP_OR:   alu_res = rs_eff | rt_eff;
      OP_XOR:  alu_res = rs_eff ^ rt_eff;
      OP_NOR:  alu_res = ~(rs_eff | rt_eff);
      OP_SLT:  alu_res = XLEN'($signed(rs_eff) < $signed(rt_eff));
      OP_SLTU: alu_res = XLEN'(rs_eff < rt_eff);
      OP_SLL:  alu_res = rs_eff << rt_eff[SHW-1:0];
      OP_SRL:  alu_res = rs_eff >> rt_eff[SHW-1:0];
      OP_SRA:  alu_res = $unsigned($signed(rs_eff) >>> rt_eff[SHW-1:0]);
      OP_ADDI: alu_res = rs_eff + imm_s;
      OP_ANDI: alu_res = rs_eff & imm_z;
      OP_ORI:  alu_res = rs_eff | imm_z;
      OP_XORI: alu_res = rs_eff ^ imm_z;
      default: alu_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    out_valid_d   = 1'b0;
    out_we_d      = 1'b0;
    redirect_d    = 1'b0;
    out_rd_d      = out_rd_q;
    out_data_d    = out_data_q;
    redirect_pc_d = redirect_pc_q;
    pend_rd_d     = pend_rd_q;
    pend_rem_d    = pend_rem_q;
    case (state_q)
      IDLE: if (in_valid) begin
        out_valid_d = 1'b1;
        out_rd_d    = rd_no;
        pend_rd_d   = rd_no;
        if (alu_ok) begin
          out_we_d   = 1'b1;
          out_data_d = alu_res;
        end else begin
          case (op_e)
            OP_BEQ, OP_BNE: begin
              redirect_d = (rs_eff == rt_eff) ^ (op_e == OP_BNE);
              if (redirect_d) redirect_pc_d = {br_tgt[XLEN-1:2], 2'b00};
            end
            OP_J_R, OP_JAL_R: begin
              redirect_d    = 1'b1;
              redirect_pc_d = {rs_eff[XLEN-1:2], 2'b00};
              if (op_e == OP_JAL_R) begin
                out_we_d   = 1'b1;
                out_data_d = pc + XLEN'(4);
              end
            end
            OP_LW: begin
              out_valid_d = 1'b0;
              out_rd_d    = out_rd_q;
              state_d     = MEM;
              cnt_d       = CW'(MEM_LAT - 1);
            end
            OP_DIVU, OP_REMU: begin
              out_valid_d = 1'b0;
              out_rd_d    = out_rd_q;
              state_d     = DIV;
              pend_rem_d  = (op_e == OP_REMU);
            end
            default: ;
          endcase
        end
      end
      MEM: begin
        if (cnt_q == '0) begin
          out_valid_d = 1'b1;
          out_we_d    = 1'b1;
          out_rd_d    = pend_rd_q;
          out_data_d  = mem_rdata;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DIV: if (div_done) begin
        out_valid_d = 1'b1;
        out_we_d    = 1'b1;
        out_rd_d    = pend_rd_q;
        out_data_d  = pend_rem_q ? div_r : div_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // r0 is hardwired; the strobe still goes out but never writes.
    if (out_rd_d == 5'd0) out_we_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      out_valid_q   <= 1'b0;
      out_we_q      <= 1'b0;
      out_rd_q      <= '0;
      out_data_q    <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      pend_rd_q     <= '0;
      pend_rem_q    <= 1'b0;
      lw_rd_q       <= '0;
      lw_data_q     <= '0;
      lw_we_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      out_valid_q   <= out_valid_d;
      out_we_q      <= out_we_d;
      out_rd_q      <= out_rd_d;
      out_data_q    <= out_data_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      pend_rd_q     <= pend_rd_d;
      pend_rem_q    <= pend_rem_d;
      // Loaded alongside the strobe so a back-to-back accept already sees it.
      if (out_valid_d && out_we_d) begin
        lw_rd_q   <= out_rd_d;
        lw_data_q <= out_data_d;
        lw_we_q   <= 1'b1;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_we      = out_we_q;
  assign out_rd      = out_rd_q;
  assign out_data    = out_data_q;
  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;
endmodule

// File: tb/tb_exec_unit_v2.sv
// Directed-vector bench for exec_unit_v2 (XLEN=32, MEM_LAT=3).
module tb_exec_unit_v2;
  import exec_pkg::*;

  logic        clk = 1'b0;
  logic        rstn, in_valid, in_ready;
  logic [4:0]  op, rs_no, rt_no, rd_no, out_rd;
  logic [31:0] rs_val, rt_val, pc, out_data, redirect_pc, mem_wdata, mem_rdata;
  logic [15:0] imm;
  logic        out_valid, out_we, redirect, mem_we, mem_re, busy;
  logic [18:0] mem_addr;
  int          nvec = 0, nerr = 0, lat, cnt;

  always #5 clk = ~clk;

  exec_unit_v2 #(.XLEN(32), .ADDR_W(19), .MEM_LAT(3)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rs_no(rs_no), .rt_no(rt_no), .rd_no(rd_no),
    .rs_val(rs_val), .rt_val(rt_val), .imm(imm), .pc(pc),
    .out_valid(out_valid), .out_we(out_we), .out_rd(out_rd), .out_data(out_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [4:0] o, input logic [4:0] s, input logic [4:0] t,
                      input logic [4:0] d, input logic [31:0] sv, input logic [31:0] tv,
                      input logic [15:0] im, input logic [31:0] p);
    op = o; rs_no = s; rt_no = t; rd_no = d;
    rs_val = sv; rt_val = tv; imm = im; pc = p; in_valid = 1'b1;
  endtask

  // Accept the offered instruction, then count cycles until out_valid (bounded).
  task automatic run(output int l);
    tick(); l = 1; in_valid = 1'b0;
    while (!out_valid && l < 60) begin tick(); l++; end
  endtask

  initial begin
    rstn = 1'b0; in_valid = 1'b0; mem_rdata = 32'h1111_1111;
    send(5'd0, 0, 0, 0, 0, 0, 0, 0); in_valid = 1'b0;
    repeat (3) tick();
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_redir", redirect, 0);
    chk("rst_data", out_data, 0);
    chk("rst_memre", mem_re, 0);
    chk("rst_busy", busy, 0);
    rstn = 1'b1; tick();

    send(OP_ADD, 1, 2, 3, 5, 7, 0, 0); tick(); in_valid = 1'b0;
    chk("add_valid", out_valid, 1);
    chk("add_data", out_data, 12);
    chk("add_we", out_we, 1);
    chk("add_rd", out_rd, 3);

    // Back-to-back forwarding through both operands
    send(OP_ADDI, 0, 0, 4, 0, 0, 16'h7FFF, 0); tick();
    chk("addi_data", out_data, 32'h7FFF);
    send(OP_ADD, 4, 4, 5, 0, 0, 0, 0); tick(); in_valid = 1'b0;
    chk("fwd_data", out_data, 32'hFFFE);

    // Write to r0 does not write and does not forward
    send(OP_ADDI, 0, 0, 0, 0, 0, 16'h7FFF, 0); tick();
    chk("r0_valid", out_valid, 1);
    chk("r0_we", out_we, 0);
    send(OP_ADD, 0, 0, 8, 3, 4, 0, 0); tick();
    chk("r0_nofwd", out_data, 7);

    // Store accepted in the same cycle as the ADD strobe; rt forwarded from r8
    send(OP_SW, 0, 8, 0, 32'h80, 32'hDEAD, 16'h4, 0); #1;
    chk("sw_ready", in_ready, 1);
    chk("sw_we", mem_we, 1);
    chk("sw_re", mem_re, 0);
    chk("sw_addr", mem_addr, 19'h21);
    chk("sw_wdata", mem_wdata, 7);
    tick(); in_valid = 1'b0;
    chk("sw_valid", out_valid, 1);
    chk("sw_owe", out_we, 0);

    send(OP_BEQ, 1, 2, 0, 5, 5, 16'hFFFE, 32'h100); tick(); in_valid = 1'b0;
    chk("beq_redir", redirect, 1);
    chk("beq_pc", redirect_pc, 32'hF8);
    chk("beq_we", out_we, 0);
    tick();
    chk("idle_redir", redirect, 0);
    chk("hold_pc", redirect_pc, 32'hF8);
    send(OP_BEQ, 1, 2, 0, 5, 6, 16'hFFFE, 32'h100); tick(); in_valid = 1'b0;
    chk("beq_nt", redirect, 0);
    chk("beq_nt_valid", out_valid, 1);
    send(OP_BNE, 1, 2, 0, 5, 6, 16'h0003, 32'h200); tick(); in_valid = 1'b0;
    chk("bne_redir", redirect, 1);
    chk("bne_pc", redirect_pc, 32'h20C);

    send(OP_JAL_R, 1, 0, 31, 32'h203, 0, 0, 32'h400); tick(); in_valid = 1'b0;
    chk("jalr_redir", redirect, 1);
    chk("jalr_pc", redirect_pc, 32'h200);
    chk("jalr_data", out_data, 32'h404);
    chk("jalr_we", out_we, 1);
    chk("jalr_rd", out_rd, 31);

    send(OP_SRA, 1, 2, 11, 32'h8000_0000, 4, 0, 0); tick();
    chk("sra", out_data, 32'hF800_0000);
    send(OP_SLT, 1, 2, 11, 32'hFFFF_FFFF, 1, 0, 0); tick();
    chk("slt", out_data, 1);
    send(OP_SLTU, 1, 2, 11, 32'hFFFF_FFFF, 1, 0, 0); tick();
    chk("sltu", out_data, 0);
    send(OP_ORI, 1, 2, 11, 0, 0, 16'h8001, 0); tick();
    chk("ori_zext", out_data, 32'h8001);
    send(OP_NOR, 1, 2, 11, 0, 32'hF0F0_F0F0, 0, 0); tick();
    chk("nor", out_data, 32'h0F0F_0F0F);
    send(OP_SLL, 1, 2, 11, 1, 32'h3F, 0, 0); tick();
    chk("sll_mask", out_data, 32'h8000_0000);
    send(5'd31, 1, 2, 5, 1, 1, 0, 0); tick(); in_valid = 1'b0;
    chk("undef_valid", out_valid, 1);
    chk("undef_we", out_we, 0);
    chk("undef_redir", redirect, 0);

    // Load: EA 0x40, data presented only in the sampling cycle T+3
    send(OP_LW, 1, 0, 12, 32'h30, 0, 16'h10, 0); #1;
    chk("lw_re", mem_re, 1);
    chk("lw_addr", mem_addr, 19'h10);
    tick(); in_valid = 1'b0;
    chk("lw_rdy1", in_ready, 0);
    chk("lw_busy", busy, 1);
    chk("lw_re_off", mem_re, 0);
    tick();
    chk("lw_rdy2", in_ready, 0);
    tick();
    chk("lw_rdy3", in_ready, 0);
    chk("lw_early", out_valid, 0);
    mem_rdata = 32'hCAFE_BABE;
    tick(); mem_rdata = 32'h1111_1111;
    chk("lw_valid", out_valid, 1);
    chk("lw_data", out_data, 32'hCAFE_BABE);
    chk("lw_rd", out_rd, 12);
    chk("lw_rdy4", in_ready, 1);

    send(OP_DIVU, 1, 2, 10, 100, 7, 0, 0); run(lat);
    chk("divu_lat", lat, 33);
    chk("divu_data", out_data, 14);
    send(OP_REMU, 1, 2, 10, 100, 7, 0, 0); run(lat);
    chk("remu_data", out_data, 2);
    send(OP_DIVU, 1, 2, 10, 32'h1234_5678, 0, 0, 0); run(lat);
    chk("div0_q", out_data, 32'hFFFF_FFFF);
    send(OP_REMU, 1, 2, 10, 32'h1234_5678, 0, 0, 0); run(lat);
    chk("div0_r", out_data, 32'h1234_5678);

    // Reset mid-divide: result abandoned, last-writeback cleared
    send(OP_DIVU, 1, 2, 13, 1000, 3, 0, 0); tick(); in_valid = 1'b0;
    repeat (10) tick();
    rstn = 1'b0; tick();
    chk("mrst_valid", out_valid, 0);
    chk("mrst_busy", busy, 0);
    rstn = 1'b1; tick();
    chk("mrst_ready", in_ready, 1);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin tick(); if (out_valid) cnt++; end
    chk("mrst_noout", cnt, 0);
    send(OP_ADD, 10, 0, 14, 1, 1, 0, 0); tick(); in_valid = 1'b0;
    chk("mrst_nofwd", out_data, 2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
